jtframe_6809_shram_arb: RTL and testbench

- Arbiter for the single-port work RAM next to a 6809 system CPU. The RAM is shared between the CPU and two secondary requesters, for example a DMA engine and a sub-CPU or video reader.
- The CPU owns the RAM by default. Device accesses are slotted in between CPU cycles.
- `bus_busy` stalls the CPU clock-enable generator while a device holds the RAM.
- A starvation counter guarantees the CPU forward progress.

---
 rtl/jtframe_6809_shram_arb.sv | 129 ++++++++++++
 tb/tb_jtframe_6809_shram_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/jtframe_6809_shram_arb.sv
// Work-RAM arbiter for a 6809 system: the CPU owns the RAM by default and two devices
// are slotted in between CPU strobes, with a starvation limit that returns the bus to the CPU.
module jtframe_6809_shram_arb #(
  parameter int AW      = 12,
  parameter int MAXWAIT = 4
) (
  input  logic              rstn,
  input  logic              clk,
  input  logic              cpu_cen,
  input  logic              cpu_cs,
  input  logic              cpu_rnw,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [7:0]        cpu_dout,
  output logic              bus_busy,
  output logic [AW-1:0]     ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [15:0]       req_din,
  output logic [1:0]        ack,
  output logic [7:0]        req_dout
);

  typedef enum logic [1:0] {IDLE, DEV_ADDR, DEV_DATA} state_t;

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            g_q, g_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      din_q, din_d;
  logic [7:0]      dout_q, dout_d;
  logic [1:0]      ack_q, ack_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            turn_q, turn_d;
  logic            grant;
  logic            sel;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    // A grant never shares a clock with a CPU strobe, so the CPU always wins a tie
    grant    = (state_q == IDLE) && (|req) && !cpu_cen && !turn_q;
    sel      = (&req) ? rr_q : req[1];
    state_d  = state_q;
    rr_d     = rr_q;
    g_d      = g_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    ack_d    = 2'b00;
    cnt_d    = cnt_q;
    turn_d   = turn_q;
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_cs & ~cpu_rnw & cpu_cen;
    unique case (state_q)
      IDLE: begin
        if (cpu_cen) begin
          cnt_d  = '0;
          turn_d = 1'b0;
        end
        if (grant) begin
          state_d = DEV_ADDR;
          g_d     = sel;
          we_d    = sel ? req_we[1] : req_we[0];
          addr_d  = sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
          din_d   = sel ? req_din[15:8] : req_din[7:0];
        end
      end
      DEV_ADDR: begin
        ram_addr = addr_q;
        ram_din  = din_q;
        ram_we   = we_q;
        state_d  = DEV_DATA;
      end
      DEV_DATA: begin
        ram_addr     = addr_q;
        ram_din      = din_q;
        ram_we       = 1'b0;
        dout_d       = ram_dout;
        ack_d[g_q]   = 1'b1;
        rr_d         = ~g_q;
        state_d      = IDLE;
        if (cpu_cs && cnt_q != MAXW) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == MAXW) turn_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cpu_cs) cnt_d = '0;
  end

  assign bus_busy = cpu_cs & ~turn_q & ((state_q != IDLE) | grant);
  assign ack      = ack_q;
  assign req_dout = dout_q;

endmodule

// File: tb/tb_jtframe_6809_shram_arb.sv
// Directed bench for jtframe_6809_shram_arb with a behavioural 1-clk-latency RAM attached.
module tb_jtframe_6809_shram_arb;
  localparam int AW = 12;

  logic            rstn, clk;
  logic            cpu_cen, cpu_cs, cpu_rnw;
  logic [AW-1:0]   cpu_addr;
  logic [7:0]      cpu_dout;
  logic            bus_busy;
  logic [AW-1:0]   ram_addr;
  logic [7:0]      ram_din;
  logic            ram_we;
  logic [7:0]      ram_dout;
  logic [1:0]      req, req_we, ack;
  logic [2*AW-1:0] req_addr;
  logic [15:0]     req_din;
  logic [7:0]      req_dout;

  logic [7:0] mem [0:(1<<AW)-1];
  int n_assert = 0;
  int n_fail   = 0;

  jtframe_6809_shram_arb #(.AW(AW), .MAXWAIT(4)) dut (
    .rstn(rstn), .clk(clk), .cpu_cen(cpu_cen), .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .bus_busy(bus_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .req(req), .req_we(req_we), .req_addr(req_addr), .req_din(req_din),
    .ack(ack), .req_dout(req_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    rstn = 1'b0; cpu_cen = 0; cpu_cs = 0; cpu_rnw = 1; cpu_addr = '0; cpu_dout = '0;
    req = 2'b11; req_we = 2'b00; req_din = 16'h0000;
    req_addr = {12'h0AB, 12'h0CD};

    // reset held with both devices requesting
    repeat (3) begin
      tick();
      chk("rst_ack", 32'(ack), 0);
      chk("rst_state", 32'(dut.state_q), 0);
      chk("rst_we", 32'(ram_we), 0);
    end
    chk("rst_dout", 32'(req_dout), 0);
    rstn = 1'b1;
    tick();
    chk("first_grant_addr", 32'(ram_addr), 32'h0CD);
    chk("first_ack0", 32'(ack), 0);
    tick();
    chk("first_ack1", 32'(ack), 0);
    tick();
    chk("first_ack2", 32'(ack), 32'b01);
    req = 2'b00;
    tick();

    // device 1 writes 0x5A at 0x123, then reads it back
    req = 2'b10; req_we = 2'b10; req_addr = {12'h123, 12'h000}; req_din = 16'h5A00;
    tick();
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_addr), 32'h123);
    chk("wr_din", 32'(ram_din), 32'h5A);
    tick();
    chk("wr_we_one_clk", 32'(ram_we), 0);
    tick();
    chk("wr_ack", 32'(ack), 32'b10);
    req = 2'b00; req_we = 2'b00;
    tick();
    req = 2'b10;
    tick();
    chk("rd_no_we", 32'(ram_we), 0);
    tick();
    tick();
    chk("rd_ack", 32'(ack), 32'b10);
    chk("rd_data", 32'(req_dout), 32'h5A);
    req = 2'b00;
    tick();

    // both devices continuously, CPU idle: strict alternation every 3 clks
    req = 2'b11; req_addr = {12'h001, 12'h002};
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i % 3 == 2) chk($sformatf("alt_ack%0d", i), 32'(ack), ((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      else            chk($sformatf("alt_ack%0d", i), 32'(ack), 0);
    end
    req = 2'b00;
    tick();

    // CPU selected and waiting: four device accesses, then the CPU gets its turn
    cpu_cs = 1'b1; cpu_rnw = 1'b1; req = 2'b11;
    #1;
    chk("starve_busy_start", 32'(bus_busy), 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i % 3 == 2) chk($sformatf("starve_ack%0d", i), 32'(ack), ((i / 3) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("starve_busy%0d", i), 32'(bus_busy), (i == 11) ? 0 : 1);
    end
    repeat (3) begin
      tick();
      chk("turn_no_ack", 32'(ack), 0);
      chk("turn_busy", 32'(bus_busy), 0);
      chk("turn_idle", 32'(dut.state_q), 0);
    end
    cpu_cen = 1'b1;
    #1;
    chk("cen_busy", 32'(bus_busy), 0);
    tick();
    cpu_cen = 1'b0;
    #1;
    chk("resume_busy", 32'(bus_busy), 1);
    tick();
    chk("resume_state", 32'(dut.state_q), 1);
    tick();
    tick();
    chk("resume_ack", 32'(ack), 32'b01);
    req = 2'b00; cpu_cs = 1'b0;
    tick();

    // CPU write and device 0 request in the same clock
    cpu_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = 12'h010; cpu_dout = 8'hC3; cpu_cen = 1'b1;
    req = 2'b01; req_we = 2'b00; req_addr = {12'h000, 12'h010};
    #1;
    chk("cpu_we", 32'(ram_we), 1);
    chk("cpu_addr", 32'(ram_addr), 32'h010);
    chk("cpu_din", 32'(ram_din), 32'hC3);
    chk("cpu_busy", 32'(bus_busy), 0);
    tick();
    cpu_cen = 1'b0; cpu_cs = 1'b0; cpu_rnw = 1'b1;
    #1;
    chk("cpu_first_idle", 32'(dut.state_q), 0);
    chk("cpu_mem", 32'(mem[12'h010]), 32'hC3);
    tick();
    chk("dev_after_cpu", 32'(dut.state_q), 1);
    tick();
    tick();
    chk("dev_after_cpu_ack", 32'(ack), 32'b01);
    chk("dev_after_cpu_data", 32'(req_dout), 32'hC3);
    req = 2'b00;
    tick();

    // reset during DEV_ADDR of a device 0 write
    req = 2'b01; req_we = 2'b01; req_addr = {12'h000, 12'h200}; req_din = 16'h0077;
    tick();
    chk("abort_we_before", 32'(ram_we), 1);
    rstn = 1'b0;
    #1;
    chk("abort_we_drop", 32'(ram_we), 0);
    chk("abort_state", 32'(dut.state_q), 0);
    tick();
    chk("abort_ack_rst", 32'(ack), 0);
    rstn = 1'b1; req = 2'b00; req_we = 2'b00;
    repeat (3) begin
      tick();
      chk("abort_ack", 32'(ack), 0);
      chk("abort_idle", 32'(dut.state_q), 0);
    end
    chk("abort_mem", 32'(mem[12'h200]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
